// File: rtl/ps2_scan_rx_if.sv
// Key-event stream between the PS/2 receiver and its consumer.
// The receiver drives the master side and the consumer drives the slave side.
interface ps2_scan_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  modport master (output ev_valid, ev_code, ev_ext, ev_brk, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_brk, output ev_ready);
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin sync/filter, 11-bit framer with timeout, E0/F0 prefix decoder, FWFT event FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not match.
module ps2_scan_rx #(
  parameter int FILTER_LEN   = 4,
  parameter int TIMEOUT_BITS = 20,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  ps2_scan_rx_if.master                   ev,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  logic [1:0]              clk_sync, data_sync;
  logic                    filt_clk;
  logic [3:0]              filt_cnt;
  logic                    sample_en;
  logic [3:0]              bit_cnt;
  logic [9:0]              shreg;
  logic [TIMEOUT_BITS-1:0] tmo_cnt;
  logic                    frame_ok;
  logic                    parity_ok;
  logic                    byte_stb;
  logic [7:0]              byte_q;
  dec_state_t              state_q, state_d;
  logic                    push_d, push_stb;
  logic [9:0]              push_word;
  logic [9:0]              mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    pop, full, do_push;

  // A falling edge is declared on the cycle the filter accepts a new low level.
  assign sample_en = filt_clk && !clk_sync[1] && (filt_cnt == 4'(FILTER_LEN - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^shreg[9:1];
`else
  assign parity_ok = 1'b1;
`endif

  // shreg[0] is the start bit, [8:1] the byte, [9] parity; the stop bit is still on the pin.
  assign frame_ok = !shreg[0] && data_sync[1] && parity_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      tmo_cnt   <= '0;
      byte_stb  <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (sample_en) begin
        tmo_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt   <= '0;
          byte_stb  <= frame_ok;
          byte_q    <= shreg[8:1];
          frame_err <= !frame_ok;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {data_sync[1], shreg[9:1]};
        end
      end else if (tmo_cnt[TIMEOUT_BITS-1]) begin
        tmo_cnt   <= '0;
        bit_cnt   <= '0;
        frame_err <= 1'b1;
      end else if (bit_cnt != 4'd0) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      push_stb  <= 1'b0;
      push_word <= '0;
    end else begin
      state_q   <= state_d;
      push_stb  <= push_d;
      push_word <= {state_q == EXT || state_q == EXT_BRK,
                    state_q == BRK || state_q == EXT_BRK, byte_q};
    end
  end

  // A discarded frame also forgets any prefix collected so far.
  always_comb begin
    state_d = state_q;
    push_d  = 1'b0;
    if (frame_err) begin
      state_d = IDLE;
    end else if (byte_stb) begin
      case (byte_q)
        8'hE0: begin
          if (state_q == IDLE)     state_d = EXT;
          else if (state_q == BRK) state_d = EXT_BRK;
        end
        8'hF0: begin
          if (state_q == IDLE)     state_d = BRK;
          else if (state_q == EXT) state_d = EXT_BRK;
        end
        default: begin
          push_d  = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign full    = (fifo_level == LW'(FIFO_DEPTH));
  assign pop     = ev.ev_valid && ev.ev_ready;
  assign do_push = push_stb && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_stb && full && !pop) overflow <= 1'b1;
      fifo_level <= fifo_level + LW'(do_push) - LW'(pop);
    end
  end

  assign ev.ev_valid = (fifo_level != '0);
  assign ev.ev_code  = ev.ev_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign ev.ev_brk   = ev.ev_valid ? mem[rd_ptr][8]   : 1'b0;
  assign ev.ev_ext   = ev.ev_valid ? mem[rd_ptr][9]   : 1'b0;
endmodule
